// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 key event queue.
package ps2_pkg;

  localparam logic [7:0] PS2_INIT   = 8'hAA;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ZERO   = 8'h00;
  localparam logic [7:0] PS2_OVR    = 8'hFF;

  // Decoder states
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_PREFIX = 2'd2;
  localparam logic [1:0] ST_SKIP   = 2'd3;

  // Pause sends E1 followed by seven more bytes that carry no key event
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam int unsigned EVT_W = 10;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  // Bytes that in IDLE either start a sequence or carry no key information
  function automatic logic idle_special(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE) || (b == PS2_ACK) ||
           (b == PS2_RESEND) || (b == PS2_ZERO) || (b == PS2_OVR) || (b == PS2_INIT);
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Byte-in / event-out bundle of the PS/2 key event queue.
interface ps2_key_event_queue_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
);
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_err;
  logic [511:0]  key_down;
  logic [8:0]    last_change;
  logic          key_valid;
  logic          kb_ready;
  logic          evt_valid;
  logic [8:0]    evt_code;
  logic          evt_break;
  logic          evt_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clr_overflow;

  // Environment side: byte source plus event consumer
  modport master (
    output byte_in, byte_valid, byte_err, evt_ready, clr_overflow,
    input  key_down, last_change, key_valid, kb_ready, evt_valid, evt_code, evt_break,
    input  fifo_count, overflow
  );

  // Decoder side
  modport slave (
    input  byte_in, byte_valid, byte_err, evt_ready, clr_overflow,
    output key_down, last_change, key_valid, kb_ready, evt_valid, evt_code, evt_break,
    output fifo_count, overflow
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan-code decoder: key_down map plus a make/break event queue.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int REPEAT_FILTER  = 1,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CW             = $clog2(FIFO_DEPTH + 1)
) (
  input logic                   clk,
  input logic                   rst,
  ps2_key_event_queue_if.slave  io_bus
);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]    r_state;
  logic          r_ext;
  logic          r_brk;
  logic [2:0]    r_skip;
  logic [TW-1:0] r_timer;
  logic [511:0]  r_key_down;
  logic [8:0]    r_last;
  logic          r_key_valid;
  logic          r_kb_ready;
  logic          r_overflow;

  logic [7:0]    w_byte;
  logic          w_bv;
  logic          w_err;
  logic [8:0]    w_code;
  logic          w_complete;
  logic          w_filtered;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_timeout;
  logic [CW-1:0] w_count;
  evt_t          w_new;
  evt_t          w_head;

  assign w_byte = io_bus.byte_in;
  assign w_bv   = io_bus.byte_valid;
  assign w_err  = io_bus.byte_err;
  assign w_code = {r_ext, w_byte};

  // Decode which byte ends a sequence and whether its event reaches the queue
  always_comb begin
    w_complete = 1'b0;
    if (w_bv && !w_err) begin
      if (r_state == ST_IDLE)   w_complete = !idle_special(w_byte);
      if (r_state == ST_PREFIX) w_complete = (w_byte != PS2_EXT) && (w_byte != PS2_BRK);
    end
    // Event would not change key_down: typematic repeat or stray break
    w_filtered = (REPEAT_FILTER != 0) && (r_key_down[w_code] == ~r_brk);
    w_push     = w_complete && !w_filtered;
    w_pop      = !w_empty && io_bus.evt_ready;
    w_new      = '{brk: r_brk, ext: r_ext, code: w_byte};
    w_timeout  = (TIMEOUT_CYCLES != 0) && !w_bv &&
                 ((r_state == ST_PREFIX) || (r_state == ST_SKIP)) &&
                 (r_timer == TW'(TIMEOUT_CYCLES - 1));
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sequence FSM, key map, prefix timer and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip      <= '0;
      r_timer     <= '0;
      r_key_down  <= '0;
      r_last      <= '0;
      r_key_valid <= 1'b0;
      r_kb_ready  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_complete) begin
        r_key_down[w_code] <= ~r_brk;
        r_last             <= w_code;
        r_key_valid        <= 1'b1;
      end

      if (r_state == ST_INIT) begin
        if (w_bv && (w_byte == PS2_INIT)) begin
          r_state    <= ST_IDLE;
          r_kb_ready <= 1'b1;
        end
      end else if (w_err) begin
        r_state <= ST_IDLE;
        r_ext   <= 1'b0;
        r_brk   <= 1'b0;
        r_timer <= '0;
      end else if (w_bv) begin
        r_timer <= '0;
        case (r_state)
          ST_IDLE: begin
            if (w_byte == PS2_EXT) begin
              r_ext   <= 1'b1;
              r_state <= ST_PREFIX;
            end else if (w_byte == PS2_BRK) begin
              r_brk   <= 1'b1;
              r_state <= ST_PREFIX;
            end else if (w_byte == PS2_PAUSE) begin
              r_skip  <= PAUSE_TAIL;
              r_state <= ST_SKIP;
            end else if (w_byte == PS2_INIT) begin
              // Keyboard re-plugged: nothing is held any more
              r_key_down <= '0;
            end
          end
          ST_PREFIX: begin
            if (w_byte == PS2_EXT) begin
              r_ext <= 1'b1;
            end else if (w_byte == PS2_BRK) begin
              r_brk <= 1'b1;
            end else begin
              r_ext   <= 1'b0;
              r_brk   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            r_skip <= r_skip - 1'b1;
            if (r_skip == 3'd1) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_ext   <= 1'b0;
        r_brk   <= 1'b0;
        r_timer <= '0;
      end else if ((r_state == ST_PREFIX) || (r_state == ST_SKIP)) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (io_bus.clr_overflow)   r_overflow <= 1'b0;
    end
  end

  assign io_bus.key_down    = r_key_down;
  assign io_bus.last_change = r_last;
  assign io_bus.key_valid   = r_key_valid;
  assign io_bus.kb_ready    = r_kb_ready;
  assign io_bus.evt_valid   = !w_empty;
  assign io_bus.evt_code    = {w_head.ext, w_head.code};
  assign io_bus.evt_break   = w_head.brk;
  assign io_bus.fifo_count  = w_count;
  assign io_bus.overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue (depth 8, repeat filter on, short timeout).
module tb_ps2_key_event_queue;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   kv_cnt = 0;
  int   kv_base;
  logic [511:0] kd_exp;

  always #5 clk = ~clk;

  ps2_key_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_queue #(
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_FILTER  (1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always @(posedge clk) if (bus.key_valid === 1'b1) kv_cnt <= kv_cnt + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the capturing posedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_err();
    @(negedge clk);
    bus.byte_err = 1'b1;
    @(negedge clk);
    bus.byte_err = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] code, input logic brk);
    chk({tag, ".valid"}, 512'(bus.evt_valid), 512'(1'b1));
    chk({tag, ".code"}, 512'(bus.evt_code), 512'(code));
    chk({tag, ".brk"}, 512'(bus.evt_break), 512'(brk));
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    bus.byte_in      = 8'h00;
    bus.byte_valid   = 1'b0;
    bus.byte_err     = 1'b0;
    bus.evt_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    kd_exp           = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst.key_down", bus.key_down, '0);
    chk("rst.last", 512'(bus.last_change), '0);
    chk("rst.kv", 512'(bus.key_valid), '0);
    chk("rst.ready", 512'(bus.kb_ready), '0);
    chk("rst.evt_valid", 512'(bus.evt_valid), '0);
    chk("rst.count", 512'(bus.fifo_count), '0);
    chk("rst.ovf", 512'(bus.overflow), '0);

    // Bytes before 0xAA are ignored
    send_byte(8'h1C);
    chk("init.kv", 512'(bus.key_valid), '0);
    chk("init.evt", 512'(bus.evt_valid), '0);
    chk("init.kd", bus.key_down, '0);
    send_byte(8'hAA);
    chk("aa.ready", 512'(bus.kb_ready), 512'(1'b1));

    // First make, one cycle latency
    send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b1;
    chk("mk.kv", 512'(bus.key_valid), 512'(1'b1));
    chk("mk.kd", bus.key_down, kd_exp);
    chk("mk.last", 512'(bus.last_change), 512'(9'h01C));
    chk("mk.count", 512'(bus.fifo_count), 512'(1));
    @(negedge clk);
    chk("mk.kv_off", 512'(bus.key_valid), '0);
    pop_chk("mk.pop", 9'h01C, 1'b0);

    // Extended make, break, make again
    send_byte(8'hE0); send_byte(8'h75);
    kd_exp[9'h175] = 1'b1;
    chk("ext.kd", bus.key_down, kd_exp);
    pop_chk("ext.mk", 9'h175, 1'b0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    kd_exp[9'h175] = 1'b0;
    chk("ext.brk_kd", bus.key_down, kd_exp);
    pop_chk("ext.brk", 9'h175, 1'b1);
    send_byte(8'hE0); send_byte(8'h75);
    kd_exp[9'h175] = 1'b1;
    chk("ext.re_kd", bus.key_down, kd_exp);
    pop_chk("ext.re", 9'h175, 1'b0);

    // Repeat filter: release 1C, then 1C 1C 1C F0 1C
    send_byte(8'hF0); send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b0;
    pop_chk("rel1c", 9'h01C, 1'b1);
    kv_base = kv_cnt;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    @(negedge clk);
    chk("flt.kv_pulses", 512'(kv_cnt - kv_base), 512'(4));
    chk("flt.count", 512'(bus.fifo_count), 512'(2));
    chk("flt.kd", bus.key_down, kd_exp);
    pop_chk("flt.mk", 9'h01C, 1'b0);
    pop_chk("flt.brk", 9'h01C, 1'b1);

    // Ten makes into a depth-8 queue
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h10 + 8'(i));
      kd_exp[9'h010 + 9'(i)] = 1'b1;
    end
    chk("ovf.count", 512'(bus.fifo_count), 512'(8));
    chk("ovf.flag", 512'(bus.overflow), 512'(1'b1));
    chk("ovf.kd", bus.key_down, kd_exp);
    @(negedge clk); bus.clr_overflow = 1'b1;
    @(negedge clk); bus.clr_overflow = 1'b0;
    chk("ovf.clr", 512'(bus.overflow), '0);

    // Push and pop together while full
    @(negedge clk);
    bus.byte_in = 8'h1A; bus.byte_valid = 1'b1; bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0; bus.evt_ready = 1'b0;
    kd_exp[9'h01A] = 1'b1;
    chk("pp.count", 512'(bus.fifo_count), 512'(8));
    chk("pp.ovf", 512'(bus.overflow), '0);
    for (int i = 1; i < 8; i++) pop_chk("drain", 9'h010 + 9'(i), 1'b0);
    pop_chk("drain.last", 9'h01A, 1'b0);
    chk("drain.empty", 512'(bus.evt_valid), '0);

    // Prefix timeout
    send_byte(8'hE0);
    repeat (TMO + 5) @(negedge clk);
    send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b1;
    chk("tmo.last", 512'(bus.last_change), 512'(9'h01C));
    chk("tmo.kd", bus.key_down, kd_exp);
    pop_chk("tmo.evt", 9'h01C, 1'b0);

    // Pause sequence is skipped
    send_byte(8'hF0); send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b0;
    pop_chk("p.rel", 9'h01C, 1'b1);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    chk("pause.none", 512'(bus.evt_valid), '0);
    send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b1;
    chk("pause.count", 512'(bus.fifo_count), 512'(1));
    chk("pause.kd", bus.key_down, kd_exp);
    pop_chk("pause.evt", 9'h01C, 1'b0);

    // byte_err discards a pending break prefix
    send_byte(8'hF0); send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b0;
    pop_chk("e.rel", 9'h01C, 1'b1);
    send_byte(8'hF0);
    send_err();
    send_byte(8'h1C);
    kd_exp[9'h01C] = 1'b1;
    chk("err.kd", bus.key_down, kd_exp);
    chk("err.brk", 512'(bus.evt_break), '0);

    // Hot-plug clears key map but keeps queued events
    send_byte(8'hAA);
    chk("hp.kd", bus.key_down, '0);
    chk("hp.count", 512'(bus.fifo_count), 512'(1));
    pop_chk("hp.evt", 9'h01C, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
